// File: rtl/demux_1x8_deser_pkg.sv
// Shared definitions for the 1-to-N deserializer: default sizes, output-buffer
// state encoding, and the bit order agreed with the 8x1 mux serializer.
package demux_1x8_deser_pkg;

  localparam int N_DEF     = 8;
  localparam int SEL_W_DEF = 3;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  typedef enum logic {
    EMPTY = ST_EMPTY,
    FULL  = ST_FULL
  } bufState_e;

  // Select 0 carries bit 0, so the serial stream is LSB first on both ends.
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/demux_1x8_deser_demux.sv
// Combinational 1-to-N demultiplexer that turns a select into a one-hot
// write enable, all zeros when not enabled.
module demux_1xN #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel receiver: demux-steered capture register feeding a
// one-deep valid/ready output buffer with a sticky overflow flag.
module demux_1x8_deser
  import demux_1x8_deser_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             din_i,
  input  logic             din_valid_i,
  input  logic             sync_i,
  output logic [N-1:0]     dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             ovf_o,
  input  logic             ovf_clr_i
);

  logic [N-1:0]     wrEn;
  logic [N-1:0]     cap_q, cap_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     dout_q;
  logic             ovf_q;
  bufState_e        state_q;
  logic             wordDone;
  logic             bufFree;
  logic [N-1:0]     fullWord;

  demux_1xN #(.N(N), .SEL_W(SEL_W)) uDemux (
    .sel_i    (sel_q),
    .en_i     (din_valid_i),
    .onehot_o (wrEn)
  );

  // A sync restarts the frame: only position 0 may hold the incoming bit.
  always_comb begin
    cap_d = cap_q;
    sel_d = sel_q;
    for (int i = 0; i < N; i++) begin
      if (wrEn[i]) cap_d[i] = din_i;
    end
    if (din_valid_i) sel_d = sel_q + SEL_W'(1);
    if (sync_i) begin
      cap_d    = '0;
      cap_d[0] = din_valid_i & din_i;
      sel_d    = din_valid_i ? SEL_W'(1) : '0;
    end
  end

  assign wordDone = din_valid_i && !sync_i && (sel_q == SEL_W'(N - 1));
  assign fullWord = {din_i, cap_q[N-2:0]};
  assign bufFree  = (state_q == EMPTY) || dout_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_q   <= '0;
      sel_q   <= '0;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= EMPTY;
    end else begin
      cap_q <= cap_d;
      sel_q <= sel_d;
      // A drop on the same edge as a clear must leave the flag set.
      if (wordDone && !bufFree) ovf_q <= 1'b1;
      else if (ovf_clr_i)       ovf_q <= 1'b0;
      case (state_q)
        EMPTY: begin
          if (wordDone) begin
            dout_q  <= fullWord;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (wordDone && dout_ready_i) dout_q  <= fullWord;
          else if (dout_ready_i)        state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = (state_q == FULL);
  assign sel_o        = sel_q;
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Self-checking bench: a queue-based model of the receive stream is compared
// against the DUT every cycle, with literal checks at key points.
module tb_demux_1x8_deser;

  localparam int N = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       din_i = 1'b0;
  logic       din_valid_i = 1'b0;
  logic       sync_i = 1'b0;
  logic [7:0] dout_o;
  logic       dout_valid_o;
  logic       dout_ready_i = 1'b0;
  logic [2:0] sel_o;
  logic       ovf_o;
  logic       ovf_clr_i = 1'b0;

  int passCount  = 0;
  int totalCount = 0;

  bit         partial[$];
  logic [7:0] mDout  = '0;
  bit         mValid = 1'b0;
  bit         mOvf   = 1'b0;
  int         mSel   = 0;

  demux_1x8_deser dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .din_i        (din_i),
    .din_valid_i  (din_valid_i),
    .sync_i       (sync_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .sel_o        (sel_o),
    .ovf_o        (ovf_o),
    .ovf_clr_i    (ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    partial.delete();
    mDout  = '0;
    mValid = 1'b0;
    mOvf   = 1'b0;
    mSel   = 0;
  endtask

  // Stream-level view: a word is whatever N bits have accumulated since the
  // last restart, with the first received bit as bit 0.
  task automatic modelStep(input bit v, input bit d, input bit s, input bit rdy, input bit clr);
    bit         done = 1'b0;
    bit         drop;
    logic [7:0] w = '0;
    if (s) begin
      partial.delete();
      if (v) partial.push_back(d);
    end else if (v) begin
      partial.push_back(d);
      if (partial.size() == N) begin
        done = 1'b1;
        foreach (partial[i]) w[i] = partial[i];
        partial.delete();
      end
    end
    drop = done && mValid && !rdy;
    if (mValid && rdy) mValid = 1'b0;
    if (done && !drop) begin
      mDout  = w;
      mValid = 1'b1;
    end
    if (clr)  mOvf = 1'b0;
    if (drop) mOvf = 1'b1;
    mSel = partial.size();
  endtask

  task automatic applyStimulus(input bit v, input bit d, input bit s, input bit rdy, input bit clr);
    din_valid_i  = v;
    din_i        = d;
    sync_i       = s;
    dout_ready_i = rdy;
    ovf_clr_i    = clr;
    @(posedge clk_i);
    modelStep(v, d, s, rdy, clr);
    #1;
    din_valid_i  = 1'b0;
    sync_i       = 1'b0;
    dout_ready_i = 1'b0;
    ovf_clr_i    = 1'b0;
  endtask

  task automatic sendWord(input logic [7:0] w, input bit rdy, input bit lastRdy);
    for (int i = 0; i < N; i++)
      applyStimulus(1'b1, w[i], 1'b0, (i == N - 1) ? lastRdy : rdy, 1'b0);
  endtask

  always @(negedge clk_i) begin
    checkOutput("cyc_dout", dout_o, mDout);
    checkOutput("cyc_valid", {7'b0, dout_valid_o}, {7'b0, mValid});
    checkOutput("cyc_sel", {5'b0, sel_o}, 8'(mSel));
    checkOutput("cyc_ovf", {7'b0, ovf_o}, {7'b0, mOvf});
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    checkOutput("rst_dout", dout_o, 8'h00);
    checkOutput("rst_sel", {5'b0, sel_o}, 8'h00);

    // Word assembly, bits 0,1,0,1,... LSB first
    sendWord(8'hAA, 1'b1, 1'b1);
    checkOutput("t1_dout", dout_o, 8'hAA);
    checkOutput("t1_valid", {7'b0, dout_valid_o}, 8'h01);
    checkOutput("t1_sel", {5'b0, sel_o}, 8'h00);
    checkOutput("t1_ovf", {7'b0, ovf_o}, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_valid_drop", {7'b0, dout_valid_o}, 8'h00);

    // Backpressure and overflow
    sendWord(8'hA5, 1'b0, 1'b0);
    sendWord(8'h3C, 1'b0, 1'b0);
    checkOutput("t2_dout", dout_o, 8'hA5);
    checkOutput("t2_valid", {7'b0, dout_valid_o}, 8'h01);
    checkOutput("t2_ovf", {7'b0, ovf_o}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_valid_drain", {7'b0, dout_valid_o}, 8'h00);
    checkOutput("t2_ovf_sticky", {7'b0, ovf_o}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_ovf_clr", {7'b0, ovf_o}, 8'h00);

    // Simultaneous drain and load
    sendWord(8'h0F, 1'b0, 1'b0);
    sendWord(8'hF0, 1'b0, 1'b1);
    checkOutput("t3_dout", dout_o, 8'hF0);
    checkOutput("t3_valid", {7'b0, dout_valid_o}, 8'h01);
    checkOutput("t3_ovf", {7'b0, ovf_o}, 8'h00);

    // Drop and clear on the same edge: set wins
    for (int i = 0; i < N; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, (i == N - 1));
    checkOutput("ovf_set_wins", {7'b0, ovf_o}, 8'h01);
    checkOutput("ovf_dout_kept", dout_o, 8'hF0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Sync on a bit, then lone sync
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_sel_sync", {5'b0, sel_o}, 8'h01);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_dout", dout_o, 8'hFE);
    checkOutput("t4_valid", {7'b0, dout_valid_o}, 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("t4_lone_sel", {5'b0, sel_o}, 8'h00);
    checkOutput("t4_lone_valid", {7'b0, dout_valid_o}, 8'h00);

    // Async reset with a word pending and a partial word in flight
    sendWord(8'h33, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_i = 1'b1;
    modelReset();
    #1;
    checkOutput("t5_dout", dout_o, 8'h00);
    checkOutput("t5_valid", {7'b0, dout_valid_o}, 8'h00);
    checkOutput("t5_sel", {5'b0, sel_o}, 8'h00);
    checkOutput("t5_ovf", {7'b0, ovf_o}, 8'h00);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    sendWord(8'h55, 1'b1, 1'b1);
    checkOutput("t5_fresh", dout_o, 8'h55);

    // Gapped input
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, (i == 0 || i == 1 || i == 6 || i == 7), 1'b0, 1'b1, 1'b0);
      if (i < N - 1) begin
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("t6_sel_hold", {5'b0, sel_o}, 8'(i + 1));
      end
    end
    checkOutput("t6_dout", dout_o, 8'hC3);
    checkOutput("t6_valid", {7'b0, dout_valid_o}, 8'h01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    @(posedge clk_i);
    #6;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/demux_1x8_deser.md
Name: demux_1x8_deser

Overview:
Serial-to-parallel receive end of the 8:1 select path. A single data bit arrives per valid cycle. An internal 3-bit select counter steers each bit through a 1-to-8 demultiplexer into bit position `sel` of a capture register. When all 8 positions are filled, the word moves to a one-deep output buffer with a valid/ready handshake. The block pairs with the 8x1 mux serializer: select 000 maps to bit 0, so bits arrive LSB first.

Parameters:
- N, 8, output word width and number of demux outputs; must be a power of 2 and at least 2.
- SEL_W, 3, select/counter width; equals log2(N).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- din, input, 1, serial data bit.
- din_valid, input, 1, din is sampled on this edge.
- sync, input, 1, frame restart; forces the select counter back to position 0.
- dout, output, N, assembled word; stable while dout_valid is high.
- dout_valid, output, 1, dout holds an unconsumed word.
- dout_ready, input, 1, consumer accepts dout on an edge where dout_valid && dout_ready.
- sel, output, SEL_W, position the next accepted bit will be written to.
- ovf, output, 1, sticky overflow flag: a completed word was dropped.
- ovf_clr, input, 1, synchronous clear of ovf.

Behaviour:
- Reset (async, any time, including mid-word or while holding output):
  - sel=0, capture register=0, dout=0, dout_valid=0, ovf=0.
  - Any partial word is discarded.
- Accept: on an edge with din_valid=1, set cap[sel] <= din and sel <= sel+1 (mod N). Only the bit at index sel changes.
- No din_valid: capture register and sel hold.
- Word completion: when din_valid=1 and sel==N-1, the full word is {din, cap[N-2:0]}.
  - If the output buffer is free, load it into dout and set dout_valid=1 on that same edge.
  - Latency: dout_valid is visible in the cycle after the Nth bit is sampled.
  - The output buffer counts as free when dout_valid==0, or when dout_valid && dout_ready on the same edge (simultaneous drain and load, no overflow).
  - If the buffer is not free, the new word is dropped and ovf<=1. dout is unchanged, and sel wraps to 0 as normal.
- Handshake:
  - dout_valid falls on an edge with dout_ready=1, unless a new word loads on that same edge.
  - dout must not change while dout_valid=1 && dout_ready=0.
  - dout_ready while dout_valid=0 has no effect.
- sync with din_valid=0: sel<=0 and the capture register is cleared. The partial word is discarded and no output is produced.
- sync with din_valid=1: the bit is written to position 0, cap[N-1:1] is cleared, and sel<=1.
  - For N=2 and sync on a bit, sel=1; completion happens on the next bit.
  - sync never itself produces a word.
- ovf:
  - Set on a dropped word.
  - ovf_clr clears it.
  - If a drop and ovf_clr occur on the same edge, set wins (ovf=1).
- The capture register is written through the one-hot enables produced by the demux decoder. There is no shifting.
- Two-state control:
  - EMPTY (dout_valid=0): goes to FULL on word completion.
  - FULL: goes to EMPTY on dout_ready with no simultaneous completion; otherwise stays FULL.

Decomposition:
- Shared package holds:
  - default N=8 and SEL_W=3;
  - the EMPTY/FULL state encoding localparams;
  - the LSB-first bit-order constant shared with the mux serializer.
- Sub-module demux_1xN (combinational):
  - inputs: sel, en=din_valid;
  - output: N-bit one-hot write enable.
  - Instantiated once.
- All registers live in the top block.

Test Plan:
1. Word assembly: after reset, send 8 bits 0,1,0,1,0,1,0,1 (sel 000..111), with dout_ready=1.
   - sel steps 0..7 and then back to 0.
   - dout=8'b10101010 and dout_valid=1 for exactly one cycle after the 8th bit.
   - ovf=0.
2. Backpressure and overflow: dout_ready=0, send 0xA5 then 0x3C, 16 bits in total.
   - dout stays 8'hA5 with dout_valid held at 1.
   - ovf=1 after the 16th bit.
   - After dout_ready=1 for one cycle, dout_valid=0 and ovf is still 1.
   - ovf_clr then gives ovf=0.
3. Simultaneous drain and load: hold 0x0F unaccepted, then send 0xF0 with dout_ready=1 on the edge that samples the 8th bit.
   - dout=8'hF0, dout_valid stays 1, ovf=0.
4. Sync: send 3 bits 1,1,1, then sync with din_valid=1 and din=0, then 7 bits of 1.
   - sel=1 immediately after the sync edge.
   - Final dout=8'hFE.
   - A lone sync without din_valid gives sel=0 and no dout_valid.
5. Reset mid-operation: assert rst asynchronously (between edges) after 5 bits, with a word pending in dout.
   - Immediately: dout=0, dout_valid=0, sel=0, ovf=0.
   - After release, a fresh 0x55 assembles correctly.
6. Gapped input: 0xC3 with din_valid toggled 1,0,1,0...
   - sel only advances on valid cycles.
   - dout=8'hC3 after 15 cycles.
